// File: rtl/pc_fetch_pkg.sv
// ============================================================================
// pc_fetch_pkg: next-PC select codes, boot/exception vectors, fetch FSM states. Rev 1.0
// ============================================================================
`default_nettype none

package pc_fetch_pkg;

    localparam logic [31:0] CPU_RESET_PC = 32'hBFC0_0000;
    localparam logic [31:0] CPU_EXC_PC   = 32'hBFC0_0380;

    // Shared with the next-PC mux in the datapath
    typedef enum logic [1:0] {
        NPC_SEQ  = 2'b00,
        NPC_BR   = 2'b01,
        NPC_ERET = 2'b10,
        NPC_EXC  = 2'b11
    } npc_sel_e;

    typedef enum logic [1:0] {
        S_BOOT = 2'b00,
        S_RUN  = 2'b01,
        S_HOLD = 2'b10
    } fetch_state_e;

    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_skid_buf.sv
// ============================================================================
// fetch_skid_buf: fetch-to-decode pc/valid register plus instruction capture while stalled. Rev 1.0
// ============================================================================
`default_nettype none

module fetch_skid_buf
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = CPU_RESET_PC
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic        load_valid,
    input  logic [31:0] load_pc,
    input  logic        load_zero,
    input  logic        hold,
    input  logic [31:0] rdata,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        zero
);

    logic        r_ibuf_valid;
    logic [31:0] r_ibuf_inst;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid        <= 1'b0;
            pc           <= RESET_PC - 32'd4;
            zero         <= 1'b0;
            r_ibuf_valid <= 1'b0;
            r_ibuf_inst  <= '0;
        end else if (load) begin
            valid        <= load_valid;
            pc           <= load_pc;
            zero         <= load_zero;
            r_ibuf_valid <= 1'b0;
        end else if (valid && hold && !r_ibuf_valid) begin
            // RAM data is only guaranteed in the first cycle after the request
            r_ibuf_valid <= 1'b1;
            r_ibuf_inst  <= rdata;
        end
    end

    always_comb begin
        inst = '0;
        if (valid && !zero) begin
            inst = r_ibuf_valid ? r_ibuf_inst : rdata;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_fetch.sv
// ============================================================================
// pc_fetch: IF stage with redirect priority, stall hold and skid buffer; FETCH_ADEL_EN adds fs_adel. Rev 1.0
// ============================================================================
`default_nettype none

module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = CPU_RESET_PC,
    parameter logic [31:0] EXC_PC   = CPU_EXC_PC
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        eret_req,
    input  logic [31:0] epc,
    input  logic        exc_req,
    input  logic        ds_allowin,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata,
    output logic [1:0]  npc_sel,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst
`ifdef FETCH_ADEL_EN
    ,
    output logic        fs_adel
`endif
);

    fetch_state_e state;
    fetch_state_e state_nxt;
    npc_sel_e     sel;
    npc_sel_e     r_hold_sel;
    logic [31:0]  r_hold_tgt;
    logic [31:0]  npc;
    logic [31:0]  load_pc;
    logic         stall;
    logic         adv;
    logic         fetch_go;
    logic         redirect_now;
    logic         misaligned;
    logic         adel_wait;
    logic         skid_zero;

    assign stall        = fs_to_ds_valid && !ds_allowin;
    assign redirect_now = eret_req || br_taken;
    assign adel_wait    = fs_to_ds_valid && skid_zero;
    assign adv          = !stall && !adel_wait;
    assign fetch_go     = resetn && (exc_req || adv);

    always_comb begin
        sel = NPC_SEQ;
        npc = seq_pc(fs_pc);
        if (exc_req) begin
            sel = NPC_EXC;
            npc = EXC_PC;
        end else if (eret_req) begin
            sel = NPC_ERET;
            npc = epc;
        end else if (br_taken) begin
            sel = NPC_BR;
            npc = br_target;
        end else if (state == S_HOLD) begin
            sel = r_hold_sel;
            npc = r_hold_tgt;
        end
    end

`ifdef FETCH_ADEL_EN
    assign misaligned = (npc[1:0] != 2'b00) && !exc_req;
    assign fs_adel    = fs_to_ds_valid && skid_zero;
`else
    assign misaligned = 1'b0;
`endif

    assign inst_sram_en   = fetch_go && !misaligned;
    assign inst_sram_addr = npc;
    assign npc_sel        = resetn ? sel : NPC_SEQ;

    // The fetch issued alongside an exception is flushed; the register is
    // parked one word before EXC_PC so the next sequential fetch re-requests it.
    assign load_pc = exc_req ? (EXC_PC - 32'd4) : npc;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_BOOT: state_nxt = S_RUN;
            S_RUN: begin
                if (!exc_req && stall && redirect_now) begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (exc_req || adv) begin
                    state_nxt = S_RUN;
                end
            end
            default: state_nxt = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hold_sel <= NPC_SEQ;
            r_hold_tgt <= '0;
        end else if (exc_req || adv) begin
            r_hold_sel <= NPC_SEQ;
            r_hold_tgt <= '0;
        end else if (stall && redirect_now) begin
            // A later redirect replaces whatever is already held
            r_hold_sel <= sel;
            r_hold_tgt <= npc;
        end
    end

    fetch_skid_buf #(
        .RESET_PC (RESET_PC)
    ) u_skid (
        .clk        (clk),
        .resetn     (resetn),
        .load       (fetch_go),
        .load_valid (!exc_req),
        .load_pc    (load_pc),
        .load_zero  (misaligned),
        .hold       (!ds_allowin),
        .rdata      (inst_sram_rdata),
        .valid      (fs_to_ds_valid),
        .pc         (fs_pc),
        .inst       (fs_inst),
        .zero       (skid_zero)
    );

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch.sv
// ============================================================================
// tb_pc_fetch: directed and randomized checks of pc_fetch against a fetch-stream model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_pc_fetch;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
    localparam logic [31:0] EXC_A  = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        br_taken = 1'b0;
    logic        eret_req = 1'b0;
    logic        exc_req = 1'b0;
    logic        ds_allowin = 1'b0;
    logic [31:0] br_target = '0;
    logic [31:0] epc = '0;
    logic [31:0] inst_sram_rdata = '0;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [1:0]  npc_sel;
    logic        fs_to_ds_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
`ifdef FETCH_ADEL_EN
    logic        fs_adel;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: what decode currently holds, where sequential fetch
    // continues, and a redirect waiting out a stall.
    bit          m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_next;
    bit          m_pend;
    logic [1:0]  m_pend_sel;
    logic [31:0] m_pend_tgt;

    pc_fetch dut (
        .clk             (clk),
        .resetn          (resetn),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .eret_req        (eret_req),
        .epc             (epc),
        .exc_req         (exc_req),
        .ds_allowin      (ds_allowin),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_rdata (inst_sram_rdata),
        .npc_sel         (npc_sel),
        .fs_to_ds_valid  (fs_to_ds_valid),
        .fs_pc           (fs_pc),
        .fs_inst         (fs_inst)
`ifdef FETCH_ADEL_EN
        ,
        .fs_adel         (fs_adel)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h3C5A_96E1;
    endfunction

    // Synchronous RAM; garbage on idle cycles so a missing capture shows up
    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= mem_word(inst_sram_addr);
        else              inst_sram_rdata <= $urandom();
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid    = 1'b0;
        m_pc       = '0;
        m_next     = RST_PC;
        m_pend     = 1'b0;
        m_pend_sel = 2'd0;
        m_pend_tgt = '0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        resetn = 1'b0; ds_allowin = 1'b0; br_taken = 1'b0; eret_req = 1'b0; exc_req = 1'b0;
        #3;
        check("rst_sram_en", 32'(inst_sram_en), 32'd0);
        check("rst_valid", 32'(fs_to_ds_valid), 32'd0);
        check("rst_fs_pc", fs_pc, RST_PC - 32'd4);
        check("rst_fs_inst", fs_inst, 32'd0);
        check("rst_npc_sel", 32'(npc_sel), 32'd0);
        @(posedge clk);
        model_reset();
    endtask

    task automatic step(input bit allow, input bit br, input logic [31:0] tgt,
                        input bit er, input logic [31:0] ep, input bit ex);
        logic [1:0]  w_sel;
        logic [31:0] w_addr;
        bit          stall;
        bit          go;
        @(posedge clk);
        #1;
        resetn = 1'b1; ds_allowin = allow; br_taken = br; br_target = tgt;
        eret_req = er; epc = ep; exc_req = ex;
        #3;
        stall = m_valid && !allow;
        go    = ex || !stall;
        if (ex)          begin w_sel = 2'd3; w_addr = EXC_A;      end
        else if (er)     begin w_sel = 2'd2; w_addr = ep;         end
        else if (br)     begin w_sel = 2'd1; w_addr = tgt;        end
        else if (m_pend) begin w_sel = m_pend_sel; w_addr = m_pend_tgt; end
        else             begin w_sel = 2'd0; w_addr = m_next;     end
        check("fs_valid", 32'(fs_to_ds_valid), 32'(m_valid));
        if (m_valid) begin
            check("fs_pc", fs_pc, m_pc);
            check("fs_inst", fs_inst, mem_word(m_pc));
        end
        check("sram_en", 32'(inst_sram_en), 32'(go));
        if (go) begin
            check("sram_addr", inst_sram_addr, w_addr);
            check("npc_sel", 32'(npc_sel), 32'(w_sel));
        end
        if (ex) begin
            m_valid = 1'b0; m_next = EXC_A; m_pend = 1'b0;
        end else if (!stall) begin
            m_valid = 1'b1; m_pc = w_addr; m_next = w_addr + 32'd4; m_pend = 1'b0;
        end else if (er || br) begin
            m_pend = 1'b1; m_pend_sel = w_sel; m_pend_tgt = w_addr;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        do_reset();

        // Boot sequence
        step(1, 0, 0, 0, 0, 0);
        check("boot_addr0", inst_sram_addr, 32'hBFC0_0000);
        step(1, 0, 0, 0, 0, 0);
        check("boot_addr1", inst_sram_addr, 32'hBFC0_0004);
        check("boot_fs_pc0", fs_pc, 32'hBFC0_0000);
        step(1, 0, 0, 0, 0, 0);
        check("boot_addr2", inst_sram_addr, 32'hBFC0_0008);

        // Three-cycle stall at BFC00008
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0);
            check("stall_fs_pc", fs_pc, 32'hBFC0_0008);
        end
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("after_stall_pc", fs_pc, 32'hBFC0_000C);

        // Branch buffered during a stall
        step(0, 1, 32'h8000_0100, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("hold_addr", inst_sram_addr, 32'h8000_0100);
        check("hold_sel", 32'(npc_sel), 32'd1);

        // All redirects at once
        step(1, 1, 32'h1234_5678, 1, 32'h0000_4000, 1);
        check("exc_sel", 32'(npc_sel), 32'd3);
        check("exc_addr", inst_sram_addr, 32'hBFC0_0380);
        step(1, 0, 0, 0, 0, 0);
        check("exc_flush", 32'(fs_to_ds_valid), 32'd0);

        // Address wrap
        step(1, 1, 32'hFFFF_FFF8, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("wrap_addr", inst_sram_addr, 32'h0000_0000);

        // Randomized traffic with a reset in the middle
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            step($urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) == 0, $urandom() & 32'hFFFF_FFFC,
                 $urandom_range(0, 19) == 0, $urandom() & 32'hFFFF_FFFC,
                 $urandom_range(0, 29) == 0);
        end

`ifdef FETCH_ADEL_EN
        step(1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        ds_allowin = 1'b1; br_taken = 1'b1; br_target = 32'h8000_0102; eret_req = 1'b0; exc_req = 1'b0;
        #3;
        check("adel_no_req", 32'(inst_sram_en), 32'd0);
        @(posedge clk);
        #1;
        br_taken = 1'b0;
        #3;
        check("adel_flag", 32'(fs_adel), 32'd1);
        check("adel_valid", 32'(fs_to_ds_valid), 32'd1);
        check("adel_pc", fs_pc, 32'h8000_0102);
        check("adel_inst", fs_inst, 32'd0);
        check("adel_wait", 32'(inst_sram_en), 32'd0);
        @(posedge clk);
        #1;
        exc_req = 1'b1;
        #3;
        check("adel_exc_addr", inst_sram_addr, EXC_A);
        check("adel_exc_en", 32'(inst_sram_en), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have parameters: RESET_PC, default 32'hBFC0_0000, first fetch address after reset; EXC_PC, default 32'hBFC0_0380, exception entry address.
REQ-002 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port resetn, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port br_taken, input, 1, branch redirect request from decode; br_target, input, 32, the branch destination.
REQ-005 SHALL have port eret_req, input, 1, return-from-exception request; epc, input, 32, the return address.
REQ-006 SHALL have port exc_req, input, 1, exception flush request.
REQ-007 SHALL have port ds_allowin, input, 1, decode can accept this cycle.
REQ-008 SHALL have ports inst_sram_en, output, 1, and inst_sram_addr, output, 32, the synchronous instruction RAM request; inst_sram_rdata, input, 32, the RAM data, valid one cycle after the request.
REQ-009 SHALL have port npc_sel, output, 2, the next-PC source select for the 4:1 next-PC mux: 00 = seq, 01 = branch, 10 = eret, 11 = exc.
REQ-010 SHALL have port fs_to_ds_valid, output, 1, plus fs_pc, output, 32, and fs_inst, output, 32, the fetch-to-decode payload.
REQ-011 SHALL have port fs_adel, output, 1, misaligned-fetch flag; present only under FETCH_ADEL_EN.

Function
REQ-012 SHALL implement FSM states BOOT, RUN, HOLD.
- BOOT: entered on reset; moves to RUN the next cycle, issuing a fetch at RESET_PC.
- RUN: fetch advances.
- HOLD: a redirect arrived while stalled and is buffered.
REQ-013 SHALL apply redirect priority exc_req > eret_req > br_taken > sequential; npc_sel encodes the winner each cycle.
REQ-014 SHALL compute next PC as: seq = pc+4 (mod 2^32, wraps FFFF_FFFC -> 0000_0000); branch = br_target; eret = epc; exc = EXC_PC.
REQ-015 SHALL assert inst_sram_en with inst_sram_addr equal to the next PC whenever the fetch advances (ds_allowin high, or fs invalid) or a redirect is taken.
REQ-016 SHALL give the instruction at fetch address A on fs_inst together with fs_pc = A, with fs_to_ds_valid high, exactly one cycle after the request.
REQ-017 SHALL, when ds_allowin is low while fs_to_ds_valid is high, hold fs_pc, fs_inst and fs_to_ds_valid stable and capture inst_sram_rdata in an internal buffer, so that no instruction is lost or duplicated.
REQ-018 SHALL, when br_taken or eret_req arrives during a stall, latch the target, enter HOLD, and issue that target on the first cycle ds_allowin rises; HOLD then returns to RUN.
REQ-019 SHALL treat exc_req as unconditional, in any state:
- fetch EXC_PC that cycle;
- drop the buffered redirect;
- deassert fs_to_ds_valid next cycle, since the in-flight instruction is flushed.
REQ-020 SHALL let the later request win when a new redirect arrives while in HOLD, subject to REQ-013 priority.

Reset
REQ-021 SHALL, while resetn is low, drive: state = BOOT, fs_to_ds_valid = 0, fs_pc = RESET_PC-4, fs_inst = 0, inst_sram_en = 0, npc_sel = 00, buffers cleared, fs_adel = 0.
REQ-022 SHALL discard any in-flight fetch on reset mid-operation; the first valid output after reset is the instruction at RESET_PC.

Configuration
REQ-023 SHALL compile the misaligned-fetch check in or out with macro FETCH_ADEL_EN.
- Defined: a fetch address with addr[1:0] != 0 suppresses inst_sram_en, delivers fs_inst = 0 with fs_adel = 1 and fs_to_ds_valid = 1 one cycle later, and fetch then waits for exc_req.
- Undefined: no fs_adel port; addr[1:0] is ignored and the RAM is accessed normally.

Structure
REQ-024 SHALL take the npc_sel encodings and the RESET_PC / EXC_PC defaults from the shared CPU package, so the next-PC mux uses the same codes.
REQ-025 SHALL be a single module; the stall buffer (pc/inst/valid skid register) MAY be a sub-module named fetch_skid_buf.

Verification
REQ-026 SHALL pass: release reset, ds_allowin = 1 -> sram addrs BFC00000, BFC00004, BFC00008; fs_pc follows one cycle later.
REQ-027 SHALL pass: ds_allowin = 0 for 3 cycles at fs_pc = BFC00008 -> fs_pc/fs_inst stable; after release, next fs_pc = BFC0000C; no duplicate.
REQ-028 SHALL pass: br_taken with br_target = 8000_0100 during a stall -> HOLD; on ds_allowin rise, sram addr 8000_0100 and npc_sel = 01.
REQ-029 SHALL pass: exc_req, eret_req and br_taken in the same cycle -> npc_sel = 11, addr BFC00380, fs_to_ds_valid = 0 next cycle.
REQ-030 SHALL pass: pc = FFFF_FFFC sequential -> next addr 0000_0000.
REQ-031 SHALL pass, with FETCH_ADEL_EN: br_target = 8000_0102 -> no RAM request, fs_adel = 1, fs_pc = 8000_0102.
